// File: rtl/intc.sv
`default_nettype none
// ============================================================================
//  Module   : intc
//  Purpose  : Programmable interrupt controller with per-source level/edge
//             latching, software mask and fixed-priority claim/EOI handshake
//             in front of the CPU HWInt[7:2] inputs. Bridge register slot.
//  Options  : INTC_SYNC_EN - route src through a 2-flop synchronizer.
//  Revision : 1.0  initial release
// ============================================================================
module intc #(
    parameter int NSRC = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:2]     Addr,
    input  logic            WE,
    input  logic [31:0]     Din,
    output logic [31:0]     Dout,
    input  logic [NSRC-1:0] src,
    output logic [NSRC+1:2] HWInt,
    output logic            IRQ
);

    localparam int              c_IDW       = 3;
    localparam logic [2:0]      c_REG_MASK  = 3'd0;
    localparam logic [2:0]      c_REG_MODE  = 3'd1;
    localparam logic [2:0]      c_REG_PEND  = 3'd2;
    localparam logic [2:0]      c_REG_CLAIM = 3'd3;
    localparam logic [2:0]      c_REG_EOI   = 3'd4;
    localparam logic [2:0]      c_REG_STAT  = 3'd5;
    localparam logic [0:0]      c_ST_IDLE   = 1'b0;
    localparam logic [0:0]      c_ST_BUSY   = 1'b1;
    localparam logic [NSRC-1:0] c_ONE       = {{(NSRC-1){1'b0}}, 1'b1};

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [NSRC-1:0]  r_mask;
    logic [NSRC-1:0]  r_mode;
    logic [NSRC-1:0]  r_pend;
    logic [NSRC-1:0]  r_s_d;
    logic [c_IDW-1:0] r_isid;

    logic [NSRC-1:0]  w_s;
    logic [NSRC-1:0]  w_rise;
    logic [NSRC-1:0]  w_pm;
    logic             w_any;
    logic [c_IDW-1:0] w_first;
    logic [2:0]       w_reg;
    logic             w_wr_mask;
    logic             w_wr_mode;
    logic             w_wr_pend;
    logic             w_wr_claim;
    logic             w_wr_eoi;
    logic             w_eoi_match;
    logic             w_valid;
    logic             w_busy;
    logic             w_claim_fire;
    logic [c_IDW-1:0] w_claim_id;
    logic [NSRC-1:0]  w_pend_clr;
    logic [NSRC-1:0]  w_pend_nxt;
    logic [NSRC-1:0]  w_hw_nxt;
    logic             w_unused_bits;

    // ------------------------------------------------------------------
    // Source conditioning
    // ------------------------------------------------------------------
`ifdef INTC_SYNC_EN
    logic [NSRC-1:0] r_sync1;
    logic [NSRC-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= src;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;
`else
    assign w_s = src;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s_d <= '0;
        end else begin
            r_s_d <= w_s;
        end
    end

    assign w_rise = w_s & ~r_s_d;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign w_reg         = Addr[4:2];
    assign w_wr_mask     = WE && (w_reg == c_REG_MASK);
    assign w_wr_mode     = WE && (w_reg == c_REG_MODE);
    assign w_wr_pend     = WE && (w_reg == c_REG_PEND);
    assign w_wr_claim    = WE && (w_reg == c_REG_CLAIM);
    assign w_wr_eoi      = WE && (w_reg == c_REG_EOI);
    assign w_eoi_match   = (Din[c_IDW-1:0] == r_isid);
    assign w_unused_bits = ^{Addr[31:5], Din[31:NSRC]};

    // Lowest set index of the enabled pending set wins.
    assign w_pm  = r_pend & r_mask;
    assign w_any = |w_pm;

    always_comb begin
        w_first = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_pm[i]) begin
                w_first = c_IDW'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Claim / EOI state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_wr_claim && w_any) begin
                    w_state_nxt = c_ST_BUSY;
                end
            end
            c_ST_BUSY: begin
                if (w_wr_eoi && w_eoi_match) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy       = 1'b0;
        w_valid      = 1'b0;
        w_claim_fire = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_valid      = w_any;
                w_claim_fire = w_any && w_wr_claim;
            end
            c_ST_BUSY: begin
                w_busy = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // The read value and the claim decision share this one encode.
    assign w_claim_id = w_valid ? w_first : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_isid <= '0;
        end else if (w_claim_fire) begin
            r_isid <= w_claim_id;
        end
    end

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= '0;
            r_mode <= '0;
        end else begin
            if (w_wr_mask) begin
                r_mask <= Din[NSRC-1:0];
            end
            if (w_wr_mode) begin
                r_mode <= Din[NSRC-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending latch: mode in effect during the cycle selects the rule, so
    // a MODE change alters behaviour only from the following edge on.
    // ------------------------------------------------------------------
    assign w_pend_clr = (w_wr_pend    ? Din[NSRC-1:0]        : '0)
                      | (w_claim_fire ? (c_ONE << w_claim_id) : '0);

    always_comb begin
        w_pend_nxt = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (r_mode[i]) begin
                w_pend_nxt[i] = w_rise[i] | (r_pend[i] & ~w_pend_clr[i]);
            end else begin
                w_pend_nxt[i] = w_s[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding to the CPU
    // ------------------------------------------------------------------
    assign w_hw_nxt = w_busy ? '0 : w_pm;

    always_ff @(posedge clk) begin
        if (reset) begin
            HWInt <= '0;
            IRQ   <= 1'b0;
        end else begin
            HWInt <= w_hw_nxt;
            IRQ   <= |w_hw_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        Dout = '0;
        case (w_reg)
            c_REG_MASK:  Dout = {{(32-NSRC){1'b0}}, r_mask};
            c_REG_MODE:  Dout = {{(32-NSRC){1'b0}}, r_mode};
            c_REG_PEND:  Dout = {{(32-NSRC){1'b0}}, r_pend};
            c_REG_CLAIM: Dout = {w_valid, {(31-c_IDW){1'b0}}, w_claim_id};
            c_REG_STAT:  Dout = {{(32-NSRC-c_IDW-1){1'b0}}, w_busy, r_isid, w_s};
            default:     Dout = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_intc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_intc
//  Purpose  : Self-checking bench for intc: directed vector table, reset
//             corner sequence and randomized traffic against a reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_intc;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic [5:0]  src;
    logic [7:2]  HWInt;
    logic        IRQ;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    intc dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .src   (src),
        .HWInt (HWInt),
        .IRQ   (IRQ)
    );

    typedef struct {
        logic [5:0]  src;
        logic        we;
        logic [2:0]  addr;
        logic [31:0] din;
        logic [31:0] dout;
        logic [5:0]  hw;
        logic        irq;
    } vec_t;

    vec_t vt[$];

    // Reference model state
    bit [5:0] m_mask, m_mode, m_pend, m_prev;
    bit       m_busy;
    int       m_isid;
    bit [5:0] m_hw;
    bit       m_irq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] s, input logic we, input logic [2:0] a,
                                input logic [31:0] d, input logic [31:0] q,
                                input logic [5:0] hw, input logic irq);
        vec_t v;
        v.src = s; v.we = we; v.addr = a; v.din = d; v.dout = q; v.hw = hw; v.irq = irq;
        return v;
    endfunction

    task automatic drive(input logic [5:0] s, input logic we, input logic [2:0] a, input logic [31:0] d);
        int r;
        r    = $urandom;
        src  = s;
        WE   = we;
        Addr = {r[26:0], a};
        Din  = d;
    endtask

    // Claim id is only meaningful when valid; in-service id only while busy.
    function automatic logic [31:0] cmp_mask(input logic [2:0] a, input logic [31:0] exp);
        if (a == 3'd3 && !exp[31]) return 32'h8000_0000;
        if (a == 3'd5 && !exp[9])  return ~32'h0000_01C0;
        return 32'hFFFF_FFFF;
    endfunction

    function automatic int lowest(input bit [5:0] v);
        for (int i = 0; i < 6; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a, input logic [5:0] s);
        int  lo;
        bit  valid;
        lo    = lowest(m_pend & m_mask);
        valid = !m_busy && (lo >= 0);
        case (a)
            3'd0: return {26'd0, m_mask};
            3'd1: return {26'd0, m_mode};
            3'd2: return {26'd0, m_pend};
            3'd3: return valid ? (32'h8000_0000 | 32'(lo)) : 32'd0;
            3'd5: return {22'd0, m_busy, 3'(m_isid), s};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_mask = 0; m_mode = 0; m_pend = 0; m_prev = 0;
        m_busy = 0; m_isid = 0; m_hw = 0; m_irq = 0;
    endtask

    task automatic model_tick(input logic [5:0] s, input logic we, input logic [2:0] a, input logic [31:0] d);
        bit [5:0] enabled, np;
        int       lo;
        bit       claim_ok;
        enabled  = m_pend & m_mask;
        lo       = lowest(enabled);
        claim_ok = we && a == 3'd3 && !m_busy && lo >= 0;
        for (int i = 0; i < 6; i++) begin
            if (!m_mode[i]) begin
                np[i] = s[i];
            end else begin
                bit rise, clr;
                rise  = s[i] && !m_prev[i];
                clr   = (we && a == 3'd2 && d[i]) || (claim_ok && lo == i);
                np[i] = rise || (m_pend[i] && !clr);
            end
        end
        m_hw  = m_busy ? 6'd0 : enabled;
        m_irq = (m_hw != 0);
        if (claim_ok) begin
            m_busy = 1; m_isid = lo;
        end else if (m_busy && we && a == 3'd4 && int'(d[2:0]) == m_isid) begin
            m_busy = 0;
        end
        if (we && a == 3'd0) m_mask = d[5:0];
        if (we && a == 3'd1) m_mode = d[5:0];
        m_pend = np;
        m_prev = s;
    endtask

    initial begin
        logic [5:0]  cur_src;
        logic [31:0] exp_q;
        logic [31:0] msk;

        reset = 1'b1;
        drive(6'd0, 1'b0, 3'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // src, we, addr, din, expected Dout (before edge), HWInt, IRQ (after edge)
        vt.push_back(mk(6'h00, 0, 3'd0, 32'h0,  32'h0,          6'h00, 0));
        vt.push_back(mk(6'h00, 0, 3'd1, 32'h0,  32'h0,          6'h00, 0));
        vt.push_back(mk(6'h00, 0, 3'd2, 32'h0,  32'h0,          6'h00, 0));
        vt.push_back(mk(6'h00, 0, 3'd3, 32'h0,  32'h0,          6'h00, 0));
        vt.push_back(mk(6'h00, 0, 3'd5, 32'h0,  32'h0,          6'h00, 0));
        vt.push_back(mk(6'h00, 1, 3'd0, 32'h3F, 32'h0,          6'h00, 0));
        vt.push_back(mk(6'h00, 0, 3'd0, 32'h0,  32'h3F,         6'h00, 0));
        vt.push_back(mk(6'h04, 0, 3'd5, 32'h0,  32'h04,         6'h00, 0));
        vt.push_back(mk(6'h04, 0, 3'd2, 32'h0,  32'h04,         6'h04, 1));
        vt.push_back(mk(6'h00, 0, 3'd3, 32'h0,  32'h8000_0002,  6'h04, 1));
        vt.push_back(mk(6'h00, 0, 3'd2, 32'h0,  32'h0,          6'h00, 0));
        vt.push_back(mk(6'h00, 1, 3'd1, 32'h3F, 32'h0,          6'h00, 0));
        vt.push_back(mk(6'h02, 0, 3'd1, 32'h0,  32'h3F,         6'h00, 0));
        vt.push_back(mk(6'h10, 0, 3'd2, 32'h0,  32'h02,         6'h02, 1));
        vt.push_back(mk(6'h00, 0, 3'd3, 32'h0,  32'h8000_0001,  6'h12, 1));
        vt.push_back(mk(6'h00, 1, 3'd3, 32'h0,  32'h8000_0001,  6'h12, 1));
        vt.push_back(mk(6'h00, 0, 3'd2, 32'h0,  32'h10,         6'h00, 0));
        vt.push_back(mk(6'h00, 0, 3'd5, 32'h0,  32'h240,        6'h00, 0));
        vt.push_back(mk(6'h00, 1, 3'd4, 32'h4,  32'h0,          6'h00, 0));
        vt.push_back(mk(6'h00, 0, 3'd5, 32'h0,  32'h240,        6'h00, 0));
        vt.push_back(mk(6'h00, 1, 3'd4, 32'h1,  32'h0,          6'h00, 0));
        vt.push_back(mk(6'h00, 0, 3'd3, 32'h0,  32'h8000_0004,  6'h10, 1));
        vt.push_back(mk(6'h00, 0, 3'd2, 32'h0,  32'h10,         6'h10, 1));
        vt.push_back(mk(6'h08, 0, 3'd0, 32'h0,  32'h3F,         6'h10, 1));
        vt.push_back(mk(6'h00, 0, 3'd2, 32'h0,  32'h18,         6'h18, 1));
        vt.push_back(mk(6'h08, 1, 3'd2, 32'h08, 32'h18,         6'h18, 1));
        vt.push_back(mk(6'h08, 0, 3'd2, 32'h0,  32'h18,         6'h18, 1));
        vt.push_back(mk(6'h08, 1, 3'd2, 32'h08, 32'h18,         6'h18, 1));
        vt.push_back(mk(6'h00, 0, 3'd2, 32'h0,  32'h10,         6'h10, 1));
        vt.push_back(mk(6'h00, 1, 3'd2, 32'h10, 32'h10,         6'h10, 1));
        vt.push_back(mk(6'h00, 0, 3'd2, 32'h0,  32'h0,          6'h00, 0));
        vt.push_back(mk(6'h00, 1, 3'd0, 32'h0,  32'h3F,         6'h00, 0));
        vt.push_back(mk(6'h04, 0, 3'd0, 32'h0,  32'h0,          6'h00, 0));
        vt.push_back(mk(6'h00, 0, 3'd3, 32'h0,  32'h0,          6'h00, 0));
        vt.push_back(mk(6'h00, 1, 3'd0, 32'h04, 32'h0,          6'h00, 0));
        vt.push_back(mk(6'h00, 0, 3'd0, 32'h0,  32'h04,         6'h04, 1));
        vt.push_back(mk(6'h00, 1, 3'd3, 32'h0,  32'h8000_0002,  6'h04, 1));
        vt.push_back(mk(6'h00, 0, 3'd5, 32'h0,  32'h280,        6'h00, 0));
        vt.push_back(mk(6'h01, 0, 3'd2, 32'h0,  32'h0,          6'h00, 0));

        foreach (vt[i]) begin
            drive(vt[i].src, vt[i].we, vt[i].addr, vt[i].din);
            #1;
            check($sformatf("vec%0d_dout", i), Dout, vt[i].dout);
            @(posedge clk);
            #1;
            WE = 1'b0;
            check($sformatf("vec%0d_hwint", i), {26'd0, HWInt}, {26'd0, vt[i].hw});
            check($sformatf("vec%0d_irq", i), {31'd0, IRQ}, {31'd0, vt[i].irq});
        end

        // Reset while BUSY with MASK/MODE/PEND non-zero
        reset = 1'b1;
        drive(6'd0, 1'b0, 3'd0, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        check("rst_hwint", {26'd0, HWInt}, 32'd0);
        check("rst_irq", {31'd0, IRQ}, 32'd0);
        for (int a = 0; a < 8; a++) begin
            drive(6'd0, 1'b0, 3'(a), 32'd0);
            #1;
            check($sformatf("rst_reg%0d", a), Dout, 32'd0);
        end

        // Randomized traffic against the reference model
        model_reset();
        cur_src = 6'd0;
        for (int n = 0; n < 3000; n++) begin
            int          op;
            logic        we;
            logic [2:0]  a;
            logic [31:0] d;
            op = $urandom_range(0, 11);
            d  = $urandom;
            we = 1'b1;
            case (op)
                0:       a = 3'd0;
                1:       a = 3'd1;
                2:       a = 3'd2;
                3, 4:    a = 3'd3;
                5, 6: begin
                    a = 3'd4;
                    d[2:0] = ($urandom_range(0, 1) == 1) ? 3'(m_isid) : 3'($urandom_range(0, 7));
                end
                7:       a = 3'($urandom_range(5, 7));
                default: begin
                    we = 1'b0;
                    a  = 3'($urandom_range(0, 7));
                end
            endcase
            if (a != 3'd1 || !we) begin
                if ($urandom_range(0, 3) == 0) cur_src = 6'($urandom);
                else if ($urandom_range(0, 2) == 0) cur_src = cur_src ^ (6'd1 << $urandom_range(0, 5));
            end
            exp_q = model_read(a, cur_src);
            msk   = cmp_mask(a, exp_q);
            drive(cur_src, we, a, d);
            #1;
            check("rnd_dout", Dout & msk, exp_q & msk);
            @(posedge clk);
            model_tick(cur_src, we, a, d);
            #1;
            WE = 1'b0;
            check("rnd_hwint", {26'd0, HWInt}, {26'd0, m_hw});
            check("rnd_irq", {31'd0, IRQ}, {31'd0, m_irq});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
